// File: rtl/autoplay_seq.sv
// Attract-mode input sequencer: after a period of player inactivity it drives
// timed synthetic active-low presses on each channel, plus a debounced board button.
module autoplay_seq #(
  parameter int                NCH     = 3,
  parameter int                CW      = 24,
  parameter int                HOLD_W  = 28,
  parameter logic [HOLD_W-1:0] HOLDOFF = 28'h0FF_FFFF,
  parameter logic [15:0]       DEB     = 16'hFFFF
) (
  input  logic              clk_pix,
  input  logic              reset,
  input  logic              enable,
  input  logic [NCH-1:0]    user_n,
  input  logic              button,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CW-1:0]     cfg_data,
  output logic [NCH-1:0]    auto_n,
  output logic              armed,
  output logic              btn_rst
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACTIVE,
    ST_GAP,
    ST_DONE
  } ch_state_t;

  function automatic logic [HOLD_W-1:0] sat_dec(input logic [HOLD_W-1:0] v);
    return (v == '0) ? v : v - HOLD_W'(1);
  endfunction

  function automatic logic deb_done(input logic [15:0] c);
    return ({1'b0, c} + 17'd1) >= {1'b0, DEB};
  endfunction

  logic [NCH-1:0]    user_p0, user_p1;
  logic              btn_p0, btn_p1;
  logic [HOLD_W-1:0] holdoff;
  logic [15:0]       deb_cnt;
  logic              activity;
  logic              arm_d;

  // Stage p0/p1: two-flop synchronizers; idle levels on reset avoid false activity
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      user_p0 <= '1;
      user_p1 <= '1;
      btn_p0  <= 1'b0;
      btn_p1  <= 1'b0;
    end else begin
      user_p0 <= user_n;
      user_p1 <= user_p0;
      btn_p0  <= button;
      btn_p1  <= btn_p0;
    end
  end

  assign activity = ~&user_p1;
  // Channels react to the same condition that loads armed, so they move in step with it
  assign arm_d    = enable && (holdoff == '0) && !activity;

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      holdoff <= HOLDOFF;
      armed   <= 1'b0;
    end else begin
      holdoff <= activity ? HOLDOFF : sat_dec(holdoff);
      armed   <= arm_d;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      deb_cnt <= '0;
      btn_rst <= 1'b0;
    end else if (btn_p1 == btn_rst) begin
      deb_cnt <= '0;
    end else if (deb_done(deb_cnt)) begin
      deb_cnt <= '0;
      btn_rst <= btn_p1;
    end else begin
      deb_cnt <= deb_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] s_reg, l_reg, p_reg;
    logic [CW-1:0] cnt, lim;
    ch_state_t     state;
    logic          out_n;
    logic          wr;

    assign wr = cfg_we && (cfg_ch == 3'(i));

    always_ff @(posedge clk_pix) begin
      if (reset) begin
        s_reg <= '0;
        l_reg <= '0;
        p_reg <= '0;
      end else if (wr) begin
        case (cfg_sel)
          2'd0:    s_reg <= cfg_data;
          2'd1:    l_reg <= cfg_data;
          2'd2:    p_reg <= cfg_data;
          default: ;
        endcase
      end
    end

    // lim captures S/L/P on phase entry so a config write never retimes a running phase
    always_ff @(posedge clk_pix) begin
      if (reset) begin
        state <= ST_IDLE;
        out_n <= 1'b1;
      end else if (!arm_d) begin
        state <= ST_IDLE;
        out_n <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_WAIT;
            cnt   <= '0;
            lim   <= s_reg;
          end
          ST_WAIT: begin
            if (cnt == lim) begin
              cnt <= CW'(1);
              if (l_reg == '0) begin
                state <= ST_GAP;
                lim   <= p_reg;
              end else begin
                state <= ST_ACTIVE;
                out_n <= 1'b0;
                lim   <= l_reg;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_ACTIVE: begin
            if (cnt == lim) begin
              state <= ST_GAP;
              out_n <= 1'b1;
              cnt   <= CW'(1);
              lim   <= p_reg;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_GAP: begin
            if (lim == '0) begin
              state <= ST_DONE;
            end else if (cnt == lim) begin
              cnt <= CW'(1);
              if (l_reg == '0) begin
                lim <= p_reg;
              end else begin
                state <= ST_ACTIVE;
                out_n <= 1'b0;
                lim   <= l_reg;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_DONE: state <= ST_DONE;
          default: begin
            state <= ST_IDLE;
            out_n <= 1'b1;
          end
        endcase
      end
    end

    assign auto_n[i] = out_n;
  end

endmodule

// File: tb/tb_autoplay_seq.sv
// Bench for autoplay_seq: scheduled expectations in a scoreboard queue, compared
// one cycle-edge at a time, plus a table of debounce vectors.
module tb_autoplay_seq;
  localparam int                NCH     = 3;
  localparam int                CW      = 8;
  localparam int                HOLD_W  = 28;
  localparam logic [HOLD_W-1:0] HOLDOFF = 28'd10;
  localparam logic [15:0]       DEB     = 16'd8;
  localparam int SIG_AUTO = 0;
  localparam int SIG_ARM  = 1;
  localparam int SIG_BTN  = 2;
  localparam int NDEB     = 30;

  logic           clk_pix;
  logic           reset;
  logic           enable;
  logic [NCH-1:0] user_n;
  logic           button;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [1:0]     cfg_sel;
  logic [CW-1:0]  cfg_data;
  logic [NCH-1:0] auto_n;
  logic           armed;
  logic           btn_rst;

  autoplay_seq #(
    .NCH(NCH), .CW(CW), .HOLD_W(HOLD_W), .HOLDOFF(HOLDOFF), .DEB(DEB)
  ) dut (
    .clk_pix(clk_pix), .reset(reset), .enable(enable), .user_n(user_n),
    .button(button), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .auto_n(auto_n), .armed(armed), .btn_rst(btn_rst)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  typedef struct {
    int          due;
    int          sig;
    logic [7:0]  exp;
    string       name;
  } exp_t;

  typedef struct {
    logic btn;
    logic exp;
  } deb_vec_t;

  exp_t     expq[$];
  deb_vec_t deb_tab[NDEB];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  task automatic push(input int due, input int sig, input logic [7:0] exp, input string name);
    exp_t e;
    e.due = due;
    e.sig = sig;
    e.exp = exp;
    e.name = name;
    expq.push_back(e);
  endtask

  task automatic drain();
    logic [7:0] act;
    for (int i = expq.size() - 1; i >= 0; i--) begin
      if (expq[i].due == cyc) begin
        case (expq[i].sig)
          SIG_AUTO: act = {5'b0, auto_n};
          SIG_ARM:  act = {7'b0, armed};
          default:  act = {7'b0, btn_rst};
        endcase
        checks++;
        if (act !== expq[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", expq[i].name, cyc, act, expq[i].exp);
        end
        expq.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
    cyc++;
    drain();
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [1:0] sel, input logic [CW-1:0] data);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_sel  = sel;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Closed-form pulse train: first fall S+1 after arming, falls every L+P, L low cycles each
  function automatic bit ch_low(input int d, input int s, input int l, input int p);
    int t;
    t = d - (s + 1);
    if (t < 0 || l == 0) return 1'b0;
    if (p == 0) return t < l;
    return (t % (l + p)) < l;
  endfunction

  function automatic logic [7:0] exp_b(input int d);
    logic [2:0] v;
    v = 3'b111;
    if (ch_low(d, 5, 3, 0)) v[0] = 1'b0;
    if (ch_low(d, 0, 2, 4)) v[1] = 1'b0;
    return {5'b0, v};
  endfunction

  // ch0 S=1: a 3-cycle pulse at d=2..4, then L=7/P=5 pulses from d=10; enable drops at d=26
  function automatic logic [7:0] exp_d(input int d);
    logic [2:0] v;
    v = 3'b111;
    if (d < 0 || d >= 26) return 8'h07;
    if ((d >= 2 && d <= 4) || (d >= 10 && ((d - 10) % 12) < 7)) v[0] = 1'b0;
    if (ch_low(d, 0, 2, 4)) v[1] = 1'b0;
    return {5'b0, v};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, e0, x, a, e1, e2, r2;

    // 1-0-1 bounce then held high; a one-row dip while high; then released
    for (int r = 0; r < NDEB; r++) begin
      deb_tab[r].btn = (r == 3) || (r >= 5 && r <= 15) || (r == 17);
      deb_tab[r].exp = (r >= 14 && r <= 26);
    end

    reset    = 1'b1;
    enable   = 1'b0;
    user_n   = '1;
    button   = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_sel  = '0;
    cfg_data = '0;

    for (int c = 1; c <= 3; c++) begin
      push(c, SIG_AUTO, 8'h07, "rst_auto");
      push(c, SIG_ARM,  8'h00, "rst_armed");
      push(c, SIG_BTN,  8'h00, "rst_btn");
    end
    run_until(3);

    reset  = 1'b0;
    enable = 1'b1;
    r0 = cyc;
    e0 = r0 + 11;
    for (int c = r0 + 1; c <= r0 + 10; c++) push(c, SIG_ARM, 8'h00, "armed_holdoff");
    for (int d = -3; d <= 25; d++) begin
      push(e0 + d, SIG_AUTO, exp_b(d), "pulse_first");
      if (d >= 0) push(e0 + d, SIG_ARM, 8'h01, "armed_first");
    end
    cfg_write(3'd0, 2'd0, 8'd5);
    cfg_write(3'd0, 2'd1, 8'd3);
    cfg_write(3'd0, 2'd2, 8'd0);
    cfg_write(3'd1, 2'd0, 8'd0);
    cfg_write(3'd1, 2'd1, 8'd2);
    cfg_write(3'd1, 2'd2, 8'd4);
    cfg_write(3'd3, 2'd0, 8'd1);
    cfg_write(3'd4, 2'd1, 8'd1);
    cfg_write(3'd0, 2'd3, 8'd1);
    cfg_write(3'd7, 2'd2, 8'd1);

    // One-cycle player press during a ch1 pulse; P write lands on the activity edge
    x  = e0 + 24;
    a  = x + 2;
    e1 = a + 11;
    run_until(x - 1);
    for (int d = -11; d <= 30; d++) begin
      push(e1 + d, SIG_AUTO, exp_d(d), "pulse_rearm");
      push(e1 + d, SIG_ARM, {7'b0, (d >= 0 && d < 26)}, "armed_rearm");
    end
    user_n = 3'b011;
    tick();
    user_n = 3'b111;
    tick();
    cfg_write(3'd0, 2'd2, 8'd5);
    cfg_write(3'd0, 2'd0, 8'd1);
    run_until(e1 + 2);
    cfg_write(3'd0, 2'd1, 8'd7);
    run_until(e1 + 25);
    enable = 1'b0;
    run_until(e1 + 30);

    // Re-arm, then reset in the middle of a pulse; configuration must return to inert
    e2 = cyc + 1;
    push(e2,     SIG_ARM,  8'h01, "armed_reenable");
    push(e2,     SIG_AUTO, 8'h07, "wait_reenable");
    push(e2 + 1, SIG_AUTO, 8'h05, "pulse_reenable");
    for (int c = e2 + 2; c <= e2 + 3; c++) begin
      push(c, SIG_AUTO, 8'h07, "rst_mid_auto");
      push(c, SIG_ARM,  8'h00, "rst_mid_armed");
      push(c, SIG_BTN,  8'h00, "rst_mid_btn");
    end
    enable = 1'b1;
    run_until(e2 + 1);
    reset = 1'b1;
    run_until(e2 + 3);
    reset = 1'b0;
    r2 = cyc;
    for (int c = r2 + 1; c <= r2 + 14; c++) begin
      push(c, SIG_AUTO, 8'h07, "inert_after_rst");
      push(c, SIG_ARM, {7'b0, (c >= r2 + 11)}, "armed_after_rst");
    end
    run_until(r2 + 14);

    for (int r = 0; r < NDEB; r++) begin
      button = deb_tab[r].btn;
      push(cyc + 1, SIG_BTN, {7'b0, deb_tab[r].exp}, "debounce");
      tick();
    end

    tick();
    tick();
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d want=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
